// File: rtl/debounce_filter_pkg.sv
// Shared types and defaults for the debounce filter.
package debounce_filter_pkg;

   // Filter FSM: two settled levels, each with a qualification state
   // that leads to the opposite level.
   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      CHECK_HI  = 2'd1,
      STABLE_HI = 2'd2,
      CHECK_LO  = 2'd3
   } deb_state_t;

   localparam int DEB_CNT_W_DEFAULT = 16;

endpackage

// File: rtl/debounce_filter_if.sv
// Signal bundle between control logic and the debounce filter.
// The master side drives the sampled level and enable.
// The slave side (the filter) returns the clean level, the edge pulses and busy.
interface debounce_filter_if;

   logic din;
   logic en;
   logic dout;
   logic rise;
   logic fall;
   logic busy;

   modport master (
      output din,
      output en,
      input  dout,
      input  rise,
      input  fall,
      input  busy
   );

   modport slave (
      input  din,
      input  en,
      output dout,
      output rise,
      output fall,
      output busy
   );

endinterface

// File: rtl/debounce_filter.sv
// Glitch filter and edge detector for slow external inputs.
// A new level is accepted only after din has held it for STABLE_CYCLES clocks
// following first detection. All outputs are registered.
// Optional feature macro: DEBOUNCE_EDGE_EN builds the rise/fall pulse flops.
// When the macro is undefined, rise/fall are tied to 0.
module debounce_filter
   import debounce_filter_pkg::*;
#(
   parameter int CNT_W         = DEB_CNT_W_DEFAULT,
   parameter int STABLE_CYCLES = 1000
) (
   input  logic              clk,
   input  logic              rst_n,
   debounce_filter_if.slave  bus
);

   localparam longint CNT_MAX = (longint'(1) << CNT_W) - longint'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   generate
      if ((STABLE_CYCLES < 1) || (longint'(STABLE_CYCLES) > CNT_MAX)) begin : g_bad_cfg
         $error("debounce_filter: STABLE_CYCLES=%0d outside 1..2**CNT_W-1 (CNT_W=%0d)",
                STABLE_CYCLES, CNT_W);
      end
   endgenerate

   deb_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             commit_hi, commit_lo;
   logic             dout_q;
   logic             busy_q;

   // Next-state, counter and commit decode. An abort (en low or din back at
   // the old level) is tested before the final count, so it always wins.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      commit_hi = 1'b0;
      commit_lo = 1'b0;
      case (state_q)
         STABLE_LO: begin
            if (bus.en && bus.din) begin
               state_d = CHECK_HI;
               cnt_d   = '0;
            end
         end
         CHECK_HI: begin
            if (!bus.en || !bus.din) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = STABLE_HI;
               cnt_d     = '0;
               commit_hi = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         STABLE_HI: begin
            if (bus.en && !bus.din) begin
               state_d = CHECK_LO;
               cnt_d   = '0;
            end
         end
         CHECK_LO: begin
            if (!bus.en || bus.din) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = STABLE_LO;
               cnt_d     = '0;
               commit_lo = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = STABLE_LO;
            cnt_d   = '0;
         end
      endcase
   end

   // State, counter, busy and debounced level registers; reset drops any pending check.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= STABLE_LO;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         dout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= (state_d == CHECK_HI) || (state_d == CHECK_LO);
         if (commit_hi) begin
            dout_q <= 1'b1;
         end else if (commit_lo) begin
            dout_q <= 1'b0;
         end
      end
   end

   assign bus.dout = dout_q;
   assign bus.busy = busy_q;

`ifdef DEBOUNCE_EDGE_EN
   logic rise_q, fall_q;

   // One-cycle edge pulses, coincident with the dout change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= commit_hi;
         fall_q <= commit_lo;
      end
   end

   assign bus.rise = rise_q;
   assign bus.fall = fall_q;
`else
   assign bus.rise = 1'b0;
   assign bus.fall = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_filter.sv
// Directed bench for debounce_filter with STABLE_CYCLES=4.
// Expected rise/fall pulses follow whichever build DEBOUNCE_EDGE_EN selects.
module tb_debounce_filter;

`ifdef DEBOUNCE_EDGE_EN
   localparam logic EDGE = 1'b1;
`else
   localparam logic EDGE = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   debounce_filter_if bus ();

   debounce_filter #(
      .CNT_W         (16),
      .STABLE_CYCLES (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic got, input logic exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   // Apply din/en at the falling edge, then land 1 time unit after the next rising edge.
   task automatic step(input logic d, input logic e);
      @(negedge clk);
      bus.din = d;
      bus.en  = e;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic d, input logic r,
                          input logic f, input logic b);
      chk({tag, ".dout"}, bus.dout, d);
      chk({tag, ".rise"}, bus.rise, r);
      chk({tag, ".fall"}, bus.fall, f);
      chk({tag, ".busy"}, bus.busy, b);
   endtask

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      rst_n   = 1'b0;
      bus.din = 1'b1;
      bus.en  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_all("por", 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      bus.din = 1'b0;
      rst_n   = 1'b1;

      // Clean rise: edges t0..t0+3 qualify, t0+4 commits.
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1);
         chk_all($sformatf("rise_q%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
      end
      step(1'b1, 1'b1);
      chk_all("rise_commit", 1'b1, EDGE, 1'b0, 1'b0);
      step(1'b1, 1'b1);
      chk_all("rise_after", 1'b1, 1'b0, 1'b0, 1'b0);

      // Clean fall: five low edges.
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1);
         chk_all($sformatf("fall_q%0d", i), 1'b1, 1'b0, 1'b0, 1'b1);
      end
      step(1'b0, 1'b1);
      chk_all("fall_commit", 1'b0, 1'b0, EDGE, 1'b0);
      step(1'b0, 1'b1);
      chk_all("fall_after", 1'b0, 1'b0, 1'b0, 1'b0);

      // Glitch: three high edges, then low.
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1);
         chk_all($sformatf("glitch_h%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
      end
      step(1'b0, 1'b1);
      chk_all("glitch_drop", 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1);
      chk_all("glitch_idle", 1'b0, 1'b0, 1'b0, 1'b0);

      // Enable abort on the final qualifying edge.
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1);
         chk_all($sformatf("abort_q%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
      end
      step(1'b1, 1'b0);
      chk_all("abort_final", 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0);
      chk_all("abort_hold", 1'b0, 1'b0, 1'b0, 1'b0);

      // Requalification after en returns needs all five edges again.
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1);
         chk_all($sformatf("requal_q%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
      end
      step(1'b1, 1'b1);
      chk_all("requal_commit", 1'b1, EDGE, 1'b0, 1'b0);

      // en low while settled high: dout holds even with din low.
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b0);
         chk_all($sformatf("en_hold%0d", i), 1'b1, 1'b0, 1'b0, 1'b0);
      end

      // Reset in the middle of a fall check clears everything without a clock edge.
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      chk_all("pre_rst", 1'b1, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      bus.din = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 1'b1);
      chk_all("post_rst", 1'b0, 1'b0, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
